// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing and phase helpers for the VGA raster generator.
package vga_timing_pkg;

  localparam int COORD_W   = 11;
  localparam int MAX_TOTAL = 2048;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 4;

  typedef logic [COORD_W-1:0] vga_coord_t;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } vga_phase_t;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic vga_phase_t phase_of(input vga_coord_t c, input int active,
                                          input int sync_start, input int back_start);
    int ci;
    ci = int'(c);
    if (ci < active)
      return ACTIVE;
    else if (ci < sync_start)
      return FRONT;
    else if (ci < back_start)
      return SYNC;
    return BACK;
  endfunction

  // Re-decode only at the boundary closing the current phase or on wrap, so zero-width
  // segments fall straight through to the following phase.
  function automatic vga_phase_t phase_step(input vga_phase_t cur, input vga_coord_t nxt,
                                            input int active, input int sync_start,
                                            input int back_start);
    int   ni;
    logic at_end;
    ni = int'(nxt);
    case (cur)
      ACTIVE:  at_end = (ni == active);
      FRONT:   at_end = (ni == sync_start);
      SYNC:    at_end = (ni == back_start);
      default: at_end = 1'b0;
    endcase
    if (at_end || ni == 0)
      return phase_of(nxt, active, sync_start, back_start);
    return cur;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate bus: the raster source drives it, pixel generators and the sync mux consume it.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic       pix_tick;
  vga_coord_t h_count;
  vga_coord_t v_count;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output pix_tick, h_count, v_count, hsync, vsync, video_on,
           line_start, frame_start, frame_count
  );

  modport slave (
    input pix_tick, h_count, v_count, hsync, vsync, video_on,
          line_start, frame_start, frame_count
  );

endinterface

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: counts 0..CLK_DIV-1 and strobes advance on the last count.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic advance
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  always_ff @(posedge clk) begin
    if (reset)
      div_q <= '0;
    else if (div_q == DIV_LAST)
      div_q <= '0;
    else
      div_q <= div_q + 1'b1;
  end

  assign advance = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: counters, H/V phase FSMs and registered sync/video/marker outputs.
// Build option VGA_TIMING_SYNC_ALIGN_EN delays hsync/vsync/video_on by one pixel.
//   state  | meaning
//   ACTIVE | visible pixels / lines
//   FRONT  | front porch
//   SYNC   | sync pulse
//   BACK   | back porch (reset parks here)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL      = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL      = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_BACK_START = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_BACK_START = V_SYNC_START + V_SYNC;

  localparam vga_coord_t H_LAST = vga_coord_t'(H_TOTAL - 1);
  localparam vga_coord_t V_LAST = vga_coord_t'(V_TOTAL - 1);
  localparam vga_phase_t H_PARK = phase_of(H_LAST, H_ACTIVE, H_SYNC_START, H_BACK_START);
  localparam vga_phase_t V_PARK = phase_of(V_LAST, V_ACTIVE, V_SYNC_START, V_BACK_START);
  localparam logic       H_ON   = (H_POL != 0);
  localparam logic       V_ON   = (V_POL != 0);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || CLK_DIV < 1) begin : g_cfg_err
    $error("vga_timing_gen: H_TOTAL/V_TOTAL above 2048 or CLK_DIV below 1");
  end

  logic       advance;
  vga_coord_t h_q, v_q, h_nxt, v_nxt;
  vga_phase_t h_state, v_state, h_ph_nxt, v_ph_nxt;
  logic       hsync_nxt, vsync_nxt, video_nxt, frame_wrap;
  logic       pix_tick_q, line_start_q, frame_start_q;
  logic       hsync_q, vsync_q, video_on_q;
  logic [7:0] frame_count_q;
`ifdef VGA_TIMING_SYNC_ALIGN_EN
  logic       hsync_d, vsync_d, video_d;
`endif

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .advance (advance)
  );

  always_comb begin
    h_nxt = h_q + 1'b1;
    v_nxt = v_q;
    if (h_q == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
    h_ph_nxt   = phase_step(h_state, h_nxt, H_ACTIVE, H_SYNC_START, H_BACK_START);
    v_ph_nxt   = phase_step(v_state, v_nxt, V_ACTIVE, V_SYNC_START, V_BACK_START);
    hsync_nxt  = (h_ph_nxt == SYNC) ? H_ON : !H_ON;
    vsync_nxt  = (v_ph_nxt == SYNC) ? V_ON : !V_ON;
    video_nxt  = (h_ph_nxt == ACTIVE) && (v_ph_nxt == ACTIVE);
    frame_wrap = (h_nxt == '0) && (v_nxt == '0);
  end

  // Every output is decoded from the next counter values so it moves on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      h_state       <= H_PARK;
      v_state       <= V_PARK;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      hsync_q       <= !H_ON;
      vsync_q       <= !V_ON;
      video_on_q    <= 1'b0;
`ifdef VGA_TIMING_SYNC_ALIGN_EN
      hsync_d       <= !H_ON;
      vsync_d       <= !V_ON;
      video_d       <= 1'b0;
`endif
    end else begin
      pix_tick_q    <= advance;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (advance) begin
        h_q           <= h_nxt;
        v_q           <= v_nxt;
        h_state       <= h_ph_nxt;
        v_state       <= v_ph_nxt;
        line_start_q  <= (h_nxt == '0);
        frame_start_q <= frame_wrap;
        if (frame_wrap)
          frame_count_q <= frame_count_q + 8'd1;
`ifdef VGA_TIMING_SYNC_ALIGN_EN
        hsync_d    <= hsync_nxt;
        vsync_d    <= vsync_nxt;
        video_d    <= video_nxt;
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
        video_on_q <= video_d;
`else
        hsync_q    <= hsync_nxt;
        vsync_q    <= vsync_nxt;
        video_on_q <= video_nxt;
`endif
      end
    end
  end

  assign vif.pix_tick    = pix_tick_q;
  assign vif.h_count     = h_q;
  assign vif.v_count     = v_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.video_on    = video_on_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_count = frame_count_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates the VGA raster: pixel-rate tick, 11-bit `h_count`/`v_count`, `hsync`/`vsync`, `video_on`, and line/frame markers.
- It is the source end of the pixel-coordinate interface. Every pixel generator in the display path (matrix brackets, digits, grid) consumes `h_count`/`v_count` and decodes its own `pixon`.
- Sits between the system clock domain and the RGB/sync output mux.
- Default timing is 640x480@60 from a 100 MHz clock.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line
- `H_FP`, default 16; `H_SYNC`, default 96; `H_BP`, default 48: horizontal porches and sync width, in pixels
- `V_ACTIVE`, default 480: visible lines
- `V_FP`, default 10; `V_SYNC`, default 2; `V_BP`, default 33: vertical porches and sync width, in lines
- `H_POL`, default 0; `V_POL`, default 0: active level of `hsync`/`vsync` (0 = active-low)
- `CLK_DIV`, default 4: system clocks per pixel, at least 1
- `clk`  in  1  system clock; one clock, all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `pix_tick`  out  1  one-`clk` pulse marking the first cycle of each new pixel
- `h_count`  out  11  current column, 0..H_TOTAL-1
- `v_count`  out  11  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, at level `H_POL` when active
- `vsync`  out  1  vertical sync, at level `V_POL` when active
- `video_on`  out  1  high inside the active area
- `line_start`  out  1  one-`clk` pulse on the first cycle of `h_count` == 0
- `frame_start`  out  1  one-`clk` pulse on the first cycle of (0,0)
- `frame_count`  out  8  count of completed frame starts; wraps 255 -> 0

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, default 800.
  - V_TOTAL is formed the same way from the vertical parameters, default 525.
- Elaboration error if H_TOTAL or V_TOTAL exceeds 2048, or if CLK_DIV < 1.
- Divider counts 0..CLK_DIV-1. The advance strobe fires when the divider is at CLK_DIV-1.
- With CLK_DIV = 1, the advance strobe fires every cycle and `pix_tick` is constantly 1 after reset.
- On advance, the horizontal counter steps:
  - `h_count` increments.
  - At H_TOTAL-1 it wraps to 0 and `v_count` increments.
  - `v_count` wraps from V_TOTAL-1 to 0.
- Horizontal phase FSM, states ACTIVE / FRONT / SYNC / BACK:
  - The state follows the `h_count` boundaries 0, H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC.
  - The vertical FSM uses the same four states on `v_count`.
- Sync and video windows (default values in brackets):
  - `hsync` is active for `h_count` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) [656,752).
  - `vsync` is active for `v_count` in [490,492).
  - `video_on` = (`h_count` < H_ACTIVE) && (`v_count` < V_ACTIVE).
- All outputs are registers, decoded from the next counter values, so they change in the same `clk` edge as the counters. No combinational paths to outputs.
- `frame_count` increments in the cycle `frame_start` asserts.
- Reset behaviour:
  - Reset parks the counters at (H_TOTAL-1, V_TOTAL-1), i.e. (799,524), so every output is consistent with blanking.
  - Reset values: `h_count` = 799, `v_count` = 524, `hsync` = !H_POL, `vsync` = !V_POL, `video_on` = 0, `pix_tick` = 0, `line_start` = 0, `frame_start` = 0, `frame_count` = 0, divider = 0.
  - Reset asserted mid-frame overrides everything in the next edge and returns all outputs to these values. No partial line is completed.

## Timing
- After `reset` falls, the first advance happens at the CLK_DIV-th edge.
- In that cycle the outputs show (0,0) with `pix_tick`, `line_start`, `frame_start` and `video_on` = 1.
- `frame_count` becomes 1 at the first frame start after reset.
- Each pixel holds for exactly CLK_DIV `clk` cycles.
- A line is H_TOTAL*CLK_DIV cycles (3200 at default); a frame is 1,680,000 cycles at default.
- `line_start` fires when `h_count` becomes 0 on every line, including blanking lines.
- `frame_start` implies `line_start` and `pix_tick`.
- Counter-to-output latency is 0 cycles unless the configuration macro is defined.

## Configuration
- `VGA_TIMING_SYNC_ALIGN_EN`
- Defined:
  - `hsync`, `vsync` and `video_on` are delayed by exactly one pixel (CLK_DIV cycles) relative to `h_count`/`v_count`.
  - This matches downstream pixel logic that registers RGB on `pix_tick`. At default timing, `hsync` asserts with `h_count` = 657 and deasserts with 753.
  - The delay registers reset to the inactive level.
- Undefined: no delay stage; behaviour as in Operation.

## Structure
- Package `vga_timing_pkg` holds:
  - the default timing constants;
  - the H_TOTAL/V_TOTAL computation;
  - the 2-bit phase enum `vga_phase_t` (ACTIVE, FRONT, SYNC, BACK);
  - the 11-bit coordinate type `vga_coord_t`.
- One sub-module, `pix_tick_gen`: the CLK_DIV divider with synchronous reset, emitting the advance strobe.

## Test plan
- Reset released, defaults:
  - At the 4th edge: (0,0), `frame_start` = 1, `video_on` = 1, `frame_count` = 1.
  - Before that: (799,524), `video_on` = 0.
- Run one line: `hsync` low for exactly 96*4 = 384 cycles starting at `h_count` = 656; `line_start` period is 3200 cycles.
- Run two frames:
  - `vsync` low for lines 490-491 only.
  - `video_on` high for 640*480*4 cycles per frame.
  - `frame_start` period is 1,680,000 cycles; `frame_count` = 2.
- Assert `reset` for one cycle at (300,200): the next cycle shows (799,524) with syncs inactive, and the restart matches the first scenario.
- CLK_DIV = 1 with H_POL = V_POL = 1: `pix_tick` constantly 1, syncs active-high, counters advance every cycle.
- With `VGA_TIMING_SYNC_ALIGN_EN` defined: `hsync` asserts at `h_count` = 657; `video_on` deasserts at `h_count` = 641.
